// File: rtl/key_bounce_gen.sv
// key_bounce_gen -- emulates a mechanical push-button on an active-low key line.
//
// Each accepted start produces one press/release sequence:
//   press bounce : an initial low segment, then 2*BOUNCE_N toggles that end low,
//                  with every segment timed by an LFSR (1..2^GLITCH_W cycles)
//   hold         : the line stays low for HOLD_CYC cycles
//   release      : the line rises, then 2*BOUNCE_N LFSR-timed toggles that end high
// done pulses for one cycle on the edge that leaves the line at its final high
// value, and press_cnt counts completed sequences (8-bit, wraps).
// abort in any busy state releases the line at once. It gives no done pulse
// and no count, and it takes priority over a completion on the same edge.
// The parameters must satisfy HOLD_CYC >= 1, HOLD_CYC < 2^CNT_W and
// GLITCH_W < CNT_W, with GLITCH_W <= 16.
//
// Ports:
//   clk        in   1  clock
//   rst_n      in   1  asynchronous active-low reset
//   start      in   1  request one sequence (sampled in IDLE only)
//   abort      in   1  terminate the current sequence immediately
//   key_out    out  1  emulated key line, 1 = released
//   busy       out  1  sequence in progress
//   done       out  1  one-cycle completion pulse
//   press_cnt  out  8  number of completed sequences
module key_bounce_gen #(
  parameter int BOUNCE_N = 6,
  parameter int GLITCH_W = 8,
  parameter int HOLD_CYC = 2_500_000,
  parameter int CNT_W    = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_BOUNCE = 2'd1,
    ST_HOLD         = 2'd2,
    ST_REL_BOUNCE   = 2'd3
  } state_e;

  // The toggle counter must reach 2*BOUNCE_N during the press bounce.
  localparam int                TOG_W        = $clog2(2 * BOUNCE_N + 2);
  localparam logic [TOG_W-1:0]  TOG_END      = TOG_W'(2 * BOUNCE_N);
  localparam logic [TOG_W-1:0]  TOG_REL_LAST = TOG_W'((BOUNCE_N > 0) ? (2 * BOUNCE_N - 1) : 0);
  localparam logic [CNT_W-1:0]  HOLD_LOAD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [15:0]       LFSR_SEED    = 16'hACE1;
  localparam bit                CLEAN        = (BOUNCE_N == 0);

  // Fibonacci LFSR step, polynomial x^16 + x^14 + x^13 + x^11 + 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  state_e             state_q, state_d;
  logic               key_q, key_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         press_cnt_q, press_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TOG_W-1:0]   tog_q, tog_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   seg_load_s;

  // A segment of L cycles loads L-1 and acts when the counter reads zero.
  assign seg_load_s = CNT_W'(lfsr_q[GLITCH_W-1:0]);

  // Next-state logic: abort first, then the per-state segment/toggle sequencing.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    press_cnt_d = press_cnt_q;
    cnt_d       = cnt_q;
    tog_d       = tog_q;
    lfsr_d      = lfsr_next(lfsr_q);

    if ((state_q != ST_IDLE) && abort) begin
      state_d = ST_IDLE;
      key_d   = 1'b1;
      busy_d  = 1'b0;
      cnt_d   = {CNT_W{1'b0}};
      tog_d   = {TOG_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A start that coincides with abort is dropped.
          if (start && !abort) begin
            key_d  = 1'b0;
            busy_d = 1'b1;
            tog_d  = {TOG_W{1'b0}};
            if (CLEAN) begin
              state_d = ST_HOLD;
              cnt_d   = HOLD_LOAD;
            end else begin
              state_d = ST_PRESS_BOUNCE;
              cnt_d   = seg_load_s;
            end
          end else begin
            key_d  = 1'b1;
            busy_d = 1'b0;
          end
        end

        ST_PRESS_BOUNCE: begin
          if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (tog_q == TOG_END) begin
            // The segment after the last toggle has expired; the line stays low.
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            key_d = ~key_q;
            tog_d = tog_q + TOG_W'(1);
            cnt_d = seg_load_s;
          end
        end

        ST_HOLD: begin
          if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            key_d = 1'b1;
            if (CLEAN) begin
              state_d     = ST_IDLE;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              press_cnt_d = press_cnt_q + 8'd1;
            end else begin
              state_d = ST_REL_BOUNCE;
              tog_d   = {TOG_W{1'b0}};
              cnt_d   = seg_load_s;
            end
          end
        end

        ST_REL_BOUNCE: begin
          if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (tog_q == TOG_REL_LAST) begin
            // Final toggle lands high: the sequence completes on this edge.
            key_d       = ~key_q;
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            press_cnt_d = press_cnt_q + 8'd1;
            tog_d       = {TOG_W{1'b0}};
          end else begin
            key_d = ~key_q;
            tog_d = tog_q + TOG_W'(1);
            cnt_d = seg_load_s;
          end
        end

        default: begin
          state_d = ST_IDLE;
          key_d   = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
          tog_d   = {TOG_W{1'b0}};
        end
      endcase
    end
  end

  // State, output and LFSR registers; reset releases the line and reseeds the LFSR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      key_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      press_cnt_q <= 8'd0;
      cnt_q       <= {CNT_W{1'b0}};
      tog_q       <= {TOG_W{1'b0}};
      lfsr_q      <= LFSR_SEED;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      press_cnt_q <= press_cnt_d;
      cnt_q       <= cnt_d;
      tog_q       <= tog_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign key_out   = key_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Testbench for key_bounce_gen: three instances cover clean edges with a
// 10-cycle hold, a 2-pair bounce with 1..4-cycle segments, and a 1-cycle
// hold used for counter wrap-around.
module tb_key_bounce_gen;

  logic clk;
  logic rst_n;

  logic c_start, c_abort, c_key, c_busy, c_done;
  logic [7:0] c_cnt;
  logic b_start, b_abort, b_key, b_busy, b_done;
  logic [7:0] b_cnt;
  logic w_start, w_abort, w_key, w_busy, w_done;
  logic [7:0] w_cnt;

  logic [7:0] c_exp, b_exp, w_exp;
  int n_vec;
  int n_err;
  int runs[$];

  key_bounce_gen #(.BOUNCE_N(0), .GLITCH_W(8), .HOLD_CYC(10), .CNT_W(30)) u_clean (
    .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort),
    .key_out(c_key), .busy(c_busy), .done(c_done), .press_cnt(c_cnt));

  key_bounce_gen #(.BOUNCE_N(2), .GLITCH_W(2), .HOLD_CYC(10), .CNT_W(30)) u_bounce (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .key_out(b_key), .busy(b_busy), .done(b_done), .press_cnt(b_cnt));

  key_bounce_gen #(.BOUNCE_N(0), .GLITCH_W(8), .HOLD_CYC(1), .CNT_W(30)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(w_start), .abort(w_abort),
    .key_out(w_key), .busy(w_busy), .done(w_done), .press_cnt(w_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    c_start = 1'b0; c_abort = 1'b0;
    b_start = 1'b0; b_abort = 1'b0;
    w_start = 1'b0; w_abort = 1'b0;
    c_exp = 8'd0; b_exp = 8'd0; w_exp = 8'd0;
    #12;
    n_vec++;
    if ({c_key, c_busy, c_done, c_cnt, b_key, b_busy, b_done, b_cnt, w_key, w_busy, w_done, w_cnt}
        !== {3'b100, 8'd0, 3'b100, 8'd0, 3'b100, 8'd0}) begin
      n_err++;
      $display("FAIL reset_values key=%b%b%b busy=%b%b%b done=%b%b%b cnt=%0d/%0d/%0d want key=111 busy=000 done=000 cnt=0",
               c_key, b_key, w_key, c_busy, b_busy, w_busy, c_done, b_done, w_done, c_cnt, b_cnt, w_cnt);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      n_vec++;
      if ({c_key, c_busy, c_done, c_cnt, b_key, b_busy, b_done, b_cnt, w_key, w_busy, w_done, w_cnt}
          !== {3'b100, 8'd0, 3'b100, 8'd0, 3'b100, 8'd0}) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d key=%b%b%b busy=%b%b%b done=%b%b%b want key=111 busy=000 done=000",
                 i, c_key, b_key, w_key, c_busy, b_busy, w_busy, c_done, b_done, w_done);
      end
    end
  endtask

  // One clean press: low for exactly 10 cycles, done in cycle 11.
  task automatic test_clean_press(input bit hammer);
    repeat ($urandom_range(0, 5)) step();
    c_start = 1'b1;
    step();
    if (!hammer) c_start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      n_vec++;
      if (c_key !== 1'b0 || c_busy !== 1'b1 || c_done !== 1'b0) begin
        n_err++;
        $display("FAIL clean_low cyc=%0d key=%b busy=%b done=%b want key=0 busy=1 done=0",
                 cyc, c_key, c_busy, c_done);
      end
      step();
    end
    c_start = 1'b0;
    c_exp = c_exp + 8'd1;
    n_vec++;
    if (c_key !== 1'b1 || c_busy !== 1'b0 || c_done !== 1'b1 || c_cnt !== c_exp) begin
      n_err++;
      $display("FAIL clean_done key=%b busy=%b done=%b cnt=%0d want key=1 busy=0 done=1 cnt=%0d",
               c_key, c_busy, c_done, c_cnt, c_exp);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if (c_key !== 1'b1 || c_busy !== 1'b0 || c_done !== 1'b0 || c_cnt !== c_exp) begin
        n_err++;
        $display("FAIL clean_after cyc=%0d key=%b busy=%b done=%b cnt=%0d want key=1 busy=0 done=0 cnt=%0d",
                 i, c_key, c_busy, c_done, c_cnt, c_exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    c_start = 1'b1;
    step();
    c_start = 1'b0;
    repeat ($urandom_range(1, 6)) step();
    rst_n = 1'b0;
    #2;
    n_vec++;
    if (c_key !== 1'b1 || c_busy !== 1'b0 || c_done !== 1'b0 || c_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_mid key=%b busy=%b done=%b cnt=%0d want key=1 busy=0 done=0 cnt=0",
               c_key, c_busy, c_done, c_cnt);
    end
    c_exp = 8'd0; b_exp = 8'd0; w_exp = 8'd0;
    step();
    rst_n = 1'b1;
    step();
    test_clean_press(1'b0);
  endtask

  task automatic test_abort();
    for (int rep = 0; rep < 4; rep++) begin
      int k;
      k = (rep == 0) ? 10 : int'($urandom_range(1, 10));
      c_start = 1'b1;
      step();
      c_start = 1'b0;
      repeat (k - 1) step();
      // Abort on edge k; edge 10 would otherwise complete the sequence.
      c_abort = 1'b1;
      step();
      c_abort = 1'b0;
      n_vec++;
      if (c_key !== 1'b1 || c_busy !== 1'b0 || c_done !== 1'b0 || c_cnt !== c_exp) begin
        n_err++;
        $display("FAIL abort_hold k=%0d key=%b busy=%b done=%b cnt=%0d want key=1 busy=0 done=0 cnt=%0d",
                 k, c_key, c_busy, c_done, c_cnt, c_exp);
      end
      for (int i = 0; i < 12; i++) begin
        step();
        n_vec++;
        if (c_key !== 1'b1 || c_busy !== 1'b0 || c_done !== 1'b0 || c_cnt !== c_exp) begin
          n_err++;
          $display("FAIL abort_quiet k=%0d cyc=%0d key=%b busy=%b done=%b cnt=%0d want key=1 busy=0 done=0 cnt=%0d",
                   k, i, c_key, c_busy, c_done, c_cnt, c_exp);
        end
      end
    end
    // Abort alone in IDLE, then start together with abort: neither starts anything.
    c_abort = 1'b1;
    for (int i = 0; i < 6; i++) begin
      c_start = (i >= 3) ? 1'b1 : 1'b0;
      step();
      n_vec++;
      if (c_key !== 1'b1 || c_busy !== 1'b0 || c_done !== 1'b0 || c_cnt !== c_exp) begin
        n_err++;
        $display("FAIL abort_idle cyc=%0d key=%b busy=%b done=%b cnt=%0d want key=1 busy=0 done=0 cnt=%0d",
                 i, c_key, c_busy, c_done, c_cnt, c_exp);
      end
    end
    c_abort = 1'b0;
    c_start = 1'b0;
    step();
    test_clean_press(1'b0);
  endtask

  // Bounced press/release: run structure L L L L (L+10) L L L L, then final high.
  task automatic test_bounce(input bit noisy);
    int falls, rises, run_len, done_cyc;
    logic prev;
    bit got_done;
    repeat ($urandom_range(0, 7)) step();
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    runs.delete();
    falls = 0; rises = 0; run_len = 0; prev = 1'b1; got_done = 1'b0; done_cyc = 0;
    for (int cyc = 1; cyc <= 200 && !got_done; cyc++) begin
      if (b_key !== prev) begin
        if (b_key === 1'b0) falls++; else rises++;
        if (cyc > 1) runs.push_back(run_len);
        run_len = 1;
      end else begin
        run_len++;
      end
      prev = b_key;
      if (b_done === 1'b1) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end else begin
        n_vec++;
        if (b_busy !== 1'b1) begin
          n_err++;
          $display("FAIL bounce_busy cyc=%0d busy=%b want 1", cyc, b_busy);
        end
        if (noisy) b_start = 1'($urandom_range(0, 1));
        step();
      end
    end
    b_start = 1'b0;
    n_vec++;
    if (!got_done) begin
      n_err++;
      $display("FAIL bounce_timeout done=0 after 200 cycles want done pulse");
    end
    b_exp = b_exp + 8'd1;
    n_vec++;
    if (falls != 5 || rises != 5 || runs.size() != 9) begin
      n_err++;
      $display("FAIL bounce_edges falls=%0d rises=%0d runs=%0d want falls=5 rises=5 runs=9",
               falls, rises, runs.size());
    end
    for (int i = 0; i < runs.size(); i++) begin
      int lo, hi;
      lo = (i == 4) ? 11 : 1;
      hi = (i == 4) ? 14 : 4;
      n_vec++;
      if (runs[i] < lo || runs[i] > hi) begin
        n_err++;
        $display("FAIL bounce_width run=%0d len=%0d want %0d..%0d", i, runs[i], lo, hi);
      end
    end
    n_vec++;
    if (b_key !== 1'b1 || b_busy !== 1'b0 || b_cnt !== b_exp) begin
      n_err++;
      $display("FAIL bounce_done cyc=%0d key=%b busy=%b cnt=%0d want key=1 busy=0 cnt=%0d",
               done_cyc, b_key, b_busy, b_cnt, b_exp);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (b_key !== 1'b1 || b_busy !== 1'b0 || b_done !== 1'b0 || b_cnt !== b_exp) begin
        n_err++;
        $display("FAIL bounce_after cyc=%0d key=%b busy=%b done=%b cnt=%0d want key=1 busy=0 done=0 cnt=%0d",
                 i, b_key, b_busy, b_done, b_cnt, b_exp);
      end
    end
  endtask

  task automatic test_bounce_abort();
    int k;
    k = int'($urandom_range(1, 12));
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    repeat (k - 1) step();
    b_abort = 1'b1;
    step();
    b_abort = 1'b0;
    n_vec++;
    if (b_key !== 1'b1 || b_busy !== 1'b0 || b_done !== 1'b0 || b_cnt !== b_exp) begin
      n_err++;
      $display("FAIL bounce_abort k=%0d key=%b busy=%b done=%b cnt=%0d want key=1 busy=0 done=0 cnt=%0d",
               k, b_key, b_busy, b_done, b_cnt, b_exp);
    end
    repeat (3) step();
    test_bounce(1'b0);
  endtask

  // Start held high: a sequence every two cycles, 256 of them wrap the count.
  task automatic test_back_to_back();
    int dones;
    dones = 0;
    w_start = 1'b1;
    for (int i = 0; i < 512; i++) begin
      step();
      if (i == 511) w_start = 1'b0;
      n_vec++;
      if (w_done !== ((i % 2) == 1)) begin
        n_err++;
        $display("FAIL b2b_done step=%0d done=%b want %b", i, w_done, ((i % 2) == 1));
      end
      if (w_done === 1'b1) begin
        dones++;
        w_exp = w_exp + 8'd1;
        n_vec++;
        if (w_cnt !== w_exp) begin
          n_err++;
          $display("FAIL b2b_cnt step=%0d cnt=%0d want %0d", i, w_cnt, w_exp);
        end
      end
    end
    n_vec++;
    if (dones != 256 || w_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL b2b_wrap dones=%0d cnt=%0d want dones=256 cnt=0", dones, w_cnt);
    end
    step();
    n_vec++;
    if (w_key !== 1'b1 || w_busy !== 1'b0 || w_done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle key=%b busy=%b done=%b want key=1 busy=0 done=0", w_key, w_busy, w_done);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_clean_press(1'b0);
    test_clean_press(1'b1);
    test_clean_press(1'b0);
    test_reset_mid();
    test_abort();
    for (int i = 0; i < 6; i++) test_bounce(i[0]);
    test_bounce_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
